// File: rtl/core_launcher_if.sv
// Bus bundle between the launcher and the load source, core, data memory and result sink.
// The launcher side is the master modport; everything it talks to sits on the slave side.
interface core_launcher_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          ld_ready;
  logic          core_reset;
  logic          core_req;
  logic          core_done;
  logic          mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data;
  logic [DW-1:0] mem_rd_data;
  logic          res_valid;
  logic [DW-1:0] res_data;
  logic          res_ready;

  modport master (
    input  ld_valid, ld_data, core_done, mem_rd_data, res_ready,
    output ld_ready, core_reset, core_req, mem_wr_en, mem_addr, mem_wr_data,
           res_valid, res_data
  );

  modport slave (
    output ld_valid, ld_data, core_done, mem_rd_data, res_ready,
    input  ld_ready, core_reset, core_req, mem_wr_en, mem_addr, mem_wr_data,
           res_valid, res_data
  );
endinterface

// File: rtl/core_launcher.sv
// Host-side run sequencer: loads operands into core data memory, runs the core
// through its req/done handshake with a timeout, then streams results back out.
module core_launcher #(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int LOAD_BASE = 0,
  parameter int LOAD_LEN  = 64,
  parameter int RES_BASE  = 64,
  parameter int RES_LEN   = 64,
  parameter int TIMEOUT   = 4096
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  core_launcher_if.master     bus,
  output logic                busy,
  output logic                finished,
  output logic                timeout_err,
  output logic [15:0]         run_cycles
);

  localparam int MAX_LEN = (LOAD_LEN > RES_LEN) ? LOAD_LEN : RES_LEN;
  localparam int IW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [IW-1:0] LOAD_LAST  = IW'((LOAD_LEN > 0) ? LOAD_LEN - 1 : 0);
  localparam logic [IW-1:0] RES_LAST   = IW'((RES_LEN > 0) ? RES_LEN - 1 : 0);
  localparam logic [AW-1:0] LOAD_BASE_A = AW'(LOAD_BASE);
  localparam logic [AW-1:0] RES_BASE_A  = AW'(RES_BASE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RST,
    S_RUN,
    S_READ,
    S_FIN
  } state_t;

  state_t        state_reg;
  logic [IW-1:0] idx_reg;
  logic          rst_cnt_reg;
  logic          done_reg;
  logic          timeout_err_reg;
  logic [15:0]   run_cycles_reg;

  logic          ld_beat;
  logic          res_beat;
  logic [15:0]   run_cycles_inc;
  logic          timeout_hit;
  logic [AW-1:0] idx_addr;

  assign ld_beat        = (state_reg == S_LOAD) && bus.ld_valid;
  assign res_beat       = (state_reg == S_READ) && bus.res_ready;
  assign run_cycles_inc = run_cycles_reg + 16'd1;
  assign timeout_hit    = (run_cycles_inc == 16'(TIMEOUT));
  assign idx_addr       = AW'(idx_reg);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= S_IDLE;
      idx_reg         <= '0;
      rst_cnt_reg     <= 1'b0;
      done_reg        <= 1'b0;
      timeout_err_reg <= 1'b0;
      run_cycles_reg  <= 16'd0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            timeout_err_reg <= 1'b0;
            run_cycles_reg  <= 16'd0;
            idx_reg         <= '0;
            rst_cnt_reg     <= 1'b0;
            done_reg        <= 1'b0;
            state_reg       <= (LOAD_LEN == 0) ? S_RST : S_LOAD;
          end
        end

        S_LOAD: begin
          if (ld_beat) begin
            if (idx_reg == LOAD_LAST) begin
              idx_reg   <= '0;
              state_reg <= S_RST;
            end else begin
              idx_reg <= idx_reg + IW'(1);
            end
          end
        end

        // Two cycles of core reset; done_reg is cleared so RUN starts from a clean view.
        S_RST: begin
          if (rst_cnt_reg) begin
            rst_cnt_reg <= 1'b0;
            done_reg    <= 1'b0;
            state_reg   <= S_RUN;
          end else begin
            rst_cnt_reg <= 1'b1;
          end
        end

        // Done is acted on one cycle after the core raises it; it takes priority over timeout.
        S_RUN: begin
          run_cycles_reg <= run_cycles_inc;
          done_reg       <= bus.core_done;
          if (done_reg) begin
            idx_reg   <= '0;
            state_reg <= (RES_LEN == 0) ? S_FIN : S_READ;
          end else if (timeout_hit) begin
            timeout_err_reg <= 1'b1;
            state_reg       <= S_FIN;
          end
        end

        S_READ: begin
          if (res_beat) begin
            if (idx_reg == RES_LAST) begin
              idx_reg   <= '0;
              state_reg <= S_FIN;
            end else begin
              idx_reg <= idx_reg + IW'(1);
            end
          end
        end

        S_FIN: begin
          state_reg <= S_IDLE;
        end

        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  // Memory address follows idx only while the launcher owns the bus; otherwise parked at 0.
  assign bus.mem_addr    = (state_reg == S_LOAD) ? (LOAD_BASE_A + idx_addr) :
                           (state_reg == S_READ) ? (RES_BASE_A + idx_addr)  : '0;
  assign bus.mem_wr_en   = ld_beat;
  assign bus.mem_wr_data = (state_reg == S_LOAD) ? bus.ld_data : {DW{1'b0}};
  assign bus.ld_ready    = (state_reg == S_LOAD);
  assign bus.core_reset  = (state_reg != S_RUN);
  assign bus.core_req    = (state_reg == S_RUN);
  assign bus.res_valid   = (state_reg == S_READ);
  assign bus.res_data    = (state_reg == S_READ) ? bus.mem_rd_data : {DW{1'b0}};

  assign busy        = (state_reg != S_IDLE);
  assign finished    = (state_reg == S_FIN);
  assign timeout_err = timeout_err_reg;
  assign run_cycles  = run_cycles_reg;

endmodule

// File: tb/tb_core_launcher.sv
// Directed bench for core_launcher: reset abort, nominal/backpressured/timeout runs,
// address wrap, zero-length load/readback and start held high.
module tb_core_launcher;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start0, start1, start2;
  logic        busy0, busy1, busy2;
  logic        finished0, finished1, finished2;
  logic        timeout_err0, timeout_err1, timeout_err2;
  logic [15:0] run_cycles0, run_cycles1, run_cycles2;

  int checks = 0;
  int errors = 0;

  core_launcher_if #(.AW(8), .DW(8)) b0 ();
  core_launcher_if #(.AW(8), .DW(8)) b1 ();
  core_launcher_if #(.AW(8), .DW(8)) b2 ();

  core_launcher #(
    .AW(8), .DW(8), .LOAD_BASE(0), .LOAD_LEN(64),
    .RES_BASE(64), .RES_LEN(64), .TIMEOUT(4096)
  ) u0 (
    .clk(clk), .reset(reset), .start(start0), .bus(b0),
    .busy(busy0), .finished(finished0), .timeout_err(timeout_err0),
    .run_cycles(run_cycles0)
  );

  core_launcher #(
    .AW(8), .DW(8), .LOAD_BASE(250), .LOAD_LEN(10),
    .RES_BASE(254), .RES_LEN(4), .TIMEOUT(64)
  ) u1 (
    .clk(clk), .reset(reset), .start(start1), .bus(b1),
    .busy(busy1), .finished(finished1), .timeout_err(timeout_err1),
    .run_cycles(run_cycles1)
  );

  core_launcher #(
    .AW(8), .DW(8), .LOAD_BASE(0), .LOAD_LEN(0),
    .RES_BASE(0), .RES_LEN(0), .TIMEOUT(64)
  ) u2 (
    .clk(clk), .reset(reset), .start(start2), .bus(b2),
    .busy(busy2), .finished(finished2), .timeout_err(timeout_err2),
    .run_cycles(run_cycles2)
  );

  // Memory + core model for u0: the core writes mem[64+k] = mem[k]^A5 in RUN cycle k+1
  // and raises done from its 100th RUN cycle when enabled.
  logic [7:0] mem0 [256];
  int         req_cnt0 = 0;
  bit         done_en0 = 1'b1;

  always @(posedge clk) begin
    if (b0.mem_wr_en) mem0[b0.mem_addr] <= b0.mem_wr_data;
    if (b0.core_reset) begin
      req_cnt0 <= 0;
    end else if (b0.core_req) begin
      if (req_cnt0 < 64) mem0[8'(64 + req_cnt0)] <= mem0[8'(req_cnt0)] ^ 8'hA5;
      req_cnt0 <= req_cnt0 + 1;
    end
  end
  assign b0.mem_rd_data = mem0[b0.mem_addr];
  assign b0.core_done   = done_en0 && b0.core_req && !b0.core_reset && (req_cnt0 >= 99);

  logic [7:0] mem1 [256];
  always @(posedge clk) begin
    if (b1.mem_wr_en) mem1[b1.mem_addr] <= b1.mem_wr_data;
  end
  assign b1.mem_rd_data = mem1[b1.mem_addr];
  assign b1.core_done   = b1.core_req;

  assign b2.mem_rd_data = 8'h5A;
  assign b2.core_done   = b2.core_req;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete u0 run from IDLE; gap/stall are percentages of idle load/result cycles.
  task automatic run0(input string name, input int gap_pct, input int stall_pct,
                      input bit expect_done, input int exp_cycles);
    int ptr = 0, rptr = 0, wr_bad = 0, rd_bad = 0, stall_bad = 0;
    int proto_bad = 0, nres = 0, fin_n = 0, cyc = 0;
    bit prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    @(posedge clk); #1; start0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0;
    chk({name, "_start_tmo_clr"}, 32'(timeout_err0), 32'd0);
    chk({name, "_start_cyc_clr"}, 32'(run_cycles0), 32'd0);

    while (fin_n == 0 && cyc < 20000) begin
      b0.ld_valid  = (ptr < 64) && (int'($urandom_range(99)) >= gap_pct);
      b0.ld_data   = 8'(ptr);
      b0.res_ready = (int'($urandom_range(99)) >= stall_pct);
      @(negedge clk);
      if (b0.ld_valid && b0.ld_ready) begin
        if (b0.mem_wr_en !== 1'b1 || b0.mem_addr !== 8'(ptr) || b0.mem_wr_data !== 8'(ptr))
          wr_bad++;
        ptr++;
      end else if (b0.mem_wr_en !== 1'b0) begin
        wr_bad++;
      end
      if (b0.res_valid && b0.res_ready) begin
        if (b0.mem_addr !== 8'(64 + rptr) || b0.res_data !== (8'(rptr) ^ 8'hA5)) rd_bad++;
        rptr++;
      end
      if (prev_stall && (b0.res_valid !== 1'b1 || b0.res_data !== prev_data)) stall_bad++;
      prev_stall = b0.res_valid && !b0.res_ready;
      prev_data  = b0.res_data;
      if (b0.core_reset === 1'b0) nres++;
      if (b0.core_req === b0.core_reset) proto_bad++;
      if (finished0) fin_n++;
      @(posedge clk); #1;
      cyc++;
    end
    b0.ld_valid  = 1'b0;
    b0.res_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (finished0) fin_n++;
    end

    chk({name, "_wr_count"},   32'(ptr), 32'd64);
    chk({name, "_wr_seq"},     32'(wr_bad), 32'd0);
    chk({name, "_rd_count"},   32'(rptr), expect_done ? 32'd64 : 32'd0);
    chk({name, "_rd_data"},    32'(rd_bad), 32'd0);
    chk({name, "_stall_hold"}, 32'(stall_bad), 32'd0);
    chk({name, "_core_rst_low"}, 32'(nres), 32'(exp_cycles));
    chk({name, "_req_vs_rst"}, 32'(proto_bad), 32'd0);
    chk({name, "_fin_pulses"}, 32'(fin_n), 32'd1);
    chk({name, "_run_cycles"}, 32'(run_cycles0), 32'(exp_cycles));
    chk({name, "_timeout_err"}, 32'(timeout_err0), expect_done ? 32'd0 : 32'd1);
    chk({name, "_idle_after"}, 32'(busy0), 32'd0);
    $display("run %s: wr=%0d rd=%0d run_cycles=%0d timeout_err=%0d", name, ptr, rptr,
             run_cycles0, timeout_err0);
  endtask

  initial begin
    int bad;
    int ptr, rptr, fin_n, idle_n, traffic;

    reset = 1'b0;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    b0.ld_valid = 1'b0; b0.ld_data = 8'h00; b0.res_ready = 1'b0;
    b1.ld_valid = 1'b0; b1.ld_data = 8'h00; b1.res_ready = 1'b0;
    b2.ld_valid = 1'b1; b2.ld_data = 8'h33; b2.res_ready = 1'b1;

    // Reset values while reset is held low.
    #12;
    chk("rst_core_reset",  32'(b0.core_reset), 32'd1);
    chk("rst_core_req",    32'(b0.core_req), 32'd0);
    chk("rst_mem_wr_en",   32'(b0.mem_wr_en), 32'd0);
    chk("rst_ld_ready",    32'(b0.ld_ready), 32'd0);
    chk("rst_res_valid",   32'(b0.res_valid), 32'd0);
    chk("rst_busy",        32'(busy0), 32'd0);
    chk("rst_finished",    32'(finished0), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err0), 32'd0);
    chk("rst_run_cycles",  32'(run_cycles0), 32'd0);
    chk("rst_mem_addr",    32'(b0.mem_addr), 32'd0);

    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; start0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0;
    chk("load_ld_ready",   32'(b0.ld_ready), 32'd1);
    chk("load_busy",       32'(busy0), 32'd1);
    chk("load_core_reset", 32'(b0.core_reset), 32'd1);

    // Ten load beats, then abort with an asynchronous reset.
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      b0.ld_valid = 1'b1;
      b0.ld_data  = 8'(i);
      @(negedge clk);
      if (b0.mem_wr_en !== 1'b1 || b0.mem_addr !== 8'(i) || b0.mem_wr_data !== 8'(i)) bad++;
      @(posedge clk); #1;
    end
    b0.ld_valid = 1'b0;
    chk("partial_wr_seq", 32'(bad), 32'd0);
    @(negedge clk);
    chk("partial_addr",   32'(b0.mem_addr), 32'd10);
    chk("partial_no_wr",  32'(b0.mem_wr_en), 32'd0);
    #1 reset = 1'b0;
    #1;
    chk("abort_ld_ready",   32'(b0.ld_ready), 32'd0);
    chk("abort_core_reset", 32'(b0.core_reset), 32'd1);
    chk("abort_busy",       32'(busy0), 32'd0);
    chk("abort_mem_addr",   32'(b0.mem_addr), 32'd0);
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_stays_idle", 32'(busy0), 32'd0);

    run0("nominal", 0, 0, 1'b1, 101);
    run0("backpressure", 30, 40, 1'b1, 101);
    done_en0 = 1'b0;
    run0("timeout", 0, 0, 1'b0, 4096);
    done_en0 = 1'b1;
    run0("after_timeout", 20, 25, 1'b1, 101);

    // Load wrap 250..255,0..3 and readback wrap 254,255,0,1 on u1.
    @(posedge clk); #1; start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    ptr = 0; rptr = 0; bad = 0; fin_n = 0;
    b1.ld_valid  = 1'b1;
    b1.res_ready = 1'b1;
    for (int c = 0; c < 200 && fin_n == 0; c++) begin
      b1.ld_data = 8'(8'h80 + ptr);
      @(negedge clk);
      if (b1.mem_wr_en === 1'b1) begin
        if (b1.mem_addr !== 8'(250 + ptr) || b1.mem_wr_data !== 8'(8'h80 + ptr)) bad++;
        ptr++;
      end
      if (b1.res_valid && b1.res_ready) begin
        if (b1.mem_addr !== 8'(254 + rptr) || b1.res_data !== 8'(8'h84 + rptr)) bad++;
        rptr++;
      end
      if (finished1) fin_n++;
      @(posedge clk); #1;
    end
    b1.ld_valid = 1'b0;
    chk("wrap_wr_count",   32'(ptr), 32'd10);
    chk("wrap_rd_count",   32'(rptr), 32'd4);
    chk("wrap_addr_data",  32'(bad), 32'd0);
    chk("wrap_fin",        32'(fin_n), 32'd1);
    chk("wrap_run_cycles", 32'(run_cycles1), 32'd2);
    $display("run wrap: wr=%0d rd=%0d run_cycles=%0d", ptr, rptr, run_cycles1);

    // Zero-length load/readback with start held high: one 6-cycle run per IDLE visit.
    start2 = 1'b1;
    fin_n = 0; idle_n = 0; traffic = 0;
    for (int c = 0; c < 36; c++) begin
      @(negedge clk);
      if (finished2) fin_n++;
      if (!busy2) idle_n++;
      if (b2.mem_wr_en || b2.res_valid || b2.ld_ready || b2.mem_addr != 8'd0) traffic++;
    end
    start2 = 1'b0;
    chk("held_fin_pulses", 32'(fin_n), 32'd6);
    chk("held_idle_cycles", 32'(idle_n), 32'd6);
    chk("held_no_traffic", 32'(traffic), 32'd0);
    chk("held_run_cycles", 32'(run_cycles2), 32'd2);
    chk("held_timeout_err", 32'(timeout_err2), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("held_released_idle", 32'(busy2), 32'd0);
    $display("run held_start: fin=%0d idle=%0d", fin_n, idle_n);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
